mtm_alu_frame_rx: RTL and testbench

Parametrised serial-frame receiver for the ALU input path. It converts the `sin` bitstream into N_OPERANDS operands of DATA_W bits plus a 3-bit opcode. The CRC4 is computed bit-serially during reception, not in one wide parallel block at frame end. It adds out_valid/err_valid strobes, opcode legality checking, and defined error recovery (line resync).

---
 rtl/mtm_alu_pkg.sv | 30 +++
 rtl/mtm_alu_crc4_serial.sv | 29 ++
 rtl/mtm_alu_frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_mtm_alu_frame_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants for the ALU serial frame receiver: FSM encodings, type bits,
// error flag pairs, CRC polynomial and opcode values.
// Latency: n/a (constants only). Backpressure: n/a.
package mtm_alu_pkg;

  // Receiver FSM encodings (plain constants so legacy tools can consume them)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TYPE    = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  // Value of the type slot that follows the start bit
  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTL  = 1'b1;

  // err_flags layout is {DATA,CRC,OP,DATA,CRC,OP}; each error sets one pair
  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  // x^4 + x + 1, the x^4 term is implicit in the shift
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

endpackage

// File: rtl/mtm_alu_crc4_serial.sv
// Bit-serial CRC4 (x^4+x+1, init 0, MSB-first LFSR), one bit per enabled cycle.
// Latency: crc reflects a bit on the cycle after it is presented with en=1.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst (async, active-high), clr (sync clear to 0), en (absorb bit_in),
//        bit_in (next covered bit), crc (current remainder).
module mtm_alu_crc4_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [3:0] crc
);
  import mtm_alu_pkg::*;

  logic fb;
  assign fb = crc[3] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 4'b0000;
    end else if (clr) begin
      crc <= 4'b0000;
    end else if (en) begin
      crc <= {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
  end

endmodule

// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver: sin bitstream -> N_OPERANDS x DATA_W operands + 3-bit opcode,
// with bit-serial CRC4, opcode legality check and resync after framing errors.
// Latency: out_valid/err_valid pulse the cycle after the edge that samples the deciding bit.
// Backpressure: none; sin is consumed one slot per clk and cannot be stalled.
// Ports: clk, rst (async, active-high), sin (idle high); operands_out (first operand
//        in MSBs), op_out, out_valid (good frame), err_flags, err_valid (new error).
module mtm_alu_frame_rx #(
  parameter int         DATA_W        = 32,
  parameter int         N_OPERANDS    = 2,
  parameter logic [7:0] LEGAL_OP_MASK = 8'h33,
  parameter int         RESYNC_BITS   = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sin,
  output logic [N_OPERANDS*DATA_W-1:0] operands_out,
  output logic [2:0]                   op_out,
  output logic                         out_valid,
  output logic [5:0]                   err_flags,
  output logic                         err_valid
);
  import mtm_alu_pkg::*;

  localparam int OPW = N_OPERANDS * DATA_W;
  localparam int NB  = OPW / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int RCW = $clog2(RESYNC_BITS + 1);

  logic [2:0]     state;
  logic [BCW-1:0] byte_cnt;
  logic [2:0]     bit_cnt;
  logic [RCW-1:0] rs_cnt;
  logic [OPW-1:0] shreg;
  // Only the low 7 ctl payload bits matter; the MSB is a fixed 0 and is shifted out
  logic [6:0]     ctl_reg;

  logic       ctl_byte;
  logic       crc_clr;
  logic       crc_en;
  logic       crc_bit;
  logic [3:0] crc;

  // byte_cnt only moves in STOP, so this is stable across TYPE/PAYLOAD/STOP
  assign ctl_byte = (byte_cnt == BCW'(NB));

  mtm_alu_crc4_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // CRC covers data bits, then a constant 1 injected on the ctl type slot,
  // then OP[2:0] (ctl payload slots 1..3). Cleared after the ctl stop bit and
  // held clear while resyncing so a dropped frame leaves no residue.
  always_comb begin
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = sin;
    case (state)
      ST_TYPE: begin
        if (ctl_byte && (sin == TYPE_CTL)) begin
          crc_en  = 1'b1;
          crc_bit = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!ctl_byte) begin
          crc_en = 1'b1;
        end else if ((bit_cnt >= 3'd1) && (bit_cnt <= 3'd3)) begin
          crc_en = 1'b1;
        end
      end
      ST_STOP: begin
        if (ctl_byte && sin) begin
          crc_clr = 1'b1;
        end
      end
      ST_ERROR: begin
        crc_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      byte_cnt     <= '0;
      bit_cnt      <= 3'd0;
      rs_cnt       <= '0;
      shreg        <= '0;
      ctl_reg      <= 7'd0;
      operands_out <= '1;
      op_out       <= 3'b111;
      out_valid    <= 1'b0;
      err_valid    <= 1'b0;
      err_flags    <= 6'd0;
    end else begin
      out_valid <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!sin) begin
            state <= ST_TYPE;
          end
        end

        ST_TYPE: begin
          if (sin != (ctl_byte ? TYPE_CTL : TYPE_DATA)) begin
            state     <= ST_ERROR;
            byte_cnt  <= '0;
            rs_cnt    <= '0;
            err_flags <= ERR_DATA;
            err_valid <= 1'b1;
          end else begin
            state   <= ST_PAYLOAD;
            bit_cnt <= 3'd0;
          end
        end

        ST_PAYLOAD: begin
          if (ctl_byte) begin
            ctl_reg <= {ctl_reg[5:0], sin};
          end else begin
            shreg <= {shreg[OPW-2:0], sin};
          end
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (!sin) begin
            state     <= ST_ERROR;
            byte_cnt  <= '0;
            rs_cnt    <= '0;
            err_flags <= ERR_DATA;
            err_valid <= 1'b1;
          end else if (!ctl_byte) begin
            byte_cnt <= byte_cnt + BCW'(1);
            state    <= ST_IDLE;
          end else begin
            byte_cnt <= '0;
            state    <= ST_IDLE;
            if (crc != ctl_reg[3:0]) begin
              err_flags <= ERR_CRC;
              err_valid <= 1'b1;
            end else if (!LEGAL_OP_MASK[ctl_reg[6:4]]) begin
              err_flags <= ERR_OP;
              err_valid <= 1'b1;
            end else begin
              operands_out <= shreg;
              op_out       <= ctl_reg[6:4];
              err_flags    <= 6'd0;
              out_valid    <= 1'b1;
            end
          end
        end

        ST_ERROR: begin
          // Leave only after RESYNC_BITS consecutive idle-high slots
          if (sin) begin
            if (rs_cnt == RCW'(RESYNC_BITS - 1)) begin
              rs_cnt <= '0;
              state  <= ST_IDLE;
            end else begin
              rs_cnt <= rs_cnt + RCW'(1);
            end
          end else begin
            rs_cnt <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
module tb_mtm_alu_frame_rx;
  import mtm_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [63:0] operands_out;
  logic [2:0]  op_out;
  logic        out_valid;
  logic [5:0]  err_flags;
  logic        err_valid;

  always #5 clk = ~clk;

  mtm_alu_frame_rx dut (
    .clk          (clk),
    .rst          (rst),
    .sin          (sin),
    .operands_out (operands_out),
    .op_out       (op_out),
    .out_valid    (out_valid),
    .err_flags    (err_flags),
    .err_valid    (err_valid)
  );

  typedef struct {
    logic        is_err;
    logic [63:0] ops;
    logic [2:0]  op;
    logic [5:0]  flags;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] last_ops = '1;
  logic [2:0]  last_op  = 3'b111;

  localparam logic [63:0] A = 64'h0123456789ABCDEF;
  localparam logic [63:0] B = 64'hFEDCBA9876543210;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && (out_valid || err_valid)) begin
      check("exclusive_strobes", 64'(out_valid & err_valid), 64'd0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: out_valid=%b err_valid=%b err_flags=%b, expected no strobe",
                 out_valid, err_valid, err_flags);
      end else begin
        e = q.pop_front();
        check("strobe_kind_is_err", 64'(err_valid), 64'(e.is_err));
        check("operands_out", operands_out, e.ops);
        check("op_out", 64'(op_out), 64'(e.op));
        check("err_flags", 64'(err_flags), 64'(e.flags));
      end
    end
  end

  function automatic logic [3:0] crc_model(input logic [63:0] ops, input logic [2:0] op);
    logic [3:0] c;
    logic [67:0] s;
    c = 4'd0;
    s = {ops, 1'b1, op};
    for (int i = 67; i >= 0; i--) begin
      if (c[3] ^ s[i]) c = {c[2:0], 1'b0} ^ 4'b0011;
      else             c = {c[2:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [7:0] ctl_of(input logic [63:0] ops, input logic [2:0] op);
    return {1'b0, op, crc_model(ops, op)};
  endfunction

  task automatic push_good(input logic [63:0] ops, input logic [2:0] op);
    q.push_back('{1'b0, ops, op, 6'd0});
    last_ops = ops;
    last_op  = op;
  endtask

  task automatic push_err(input logic [5:0] flags);
    q.push_back('{1'b1, last_ops, last_op, flags});
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic typ, input logic [7:0] pay, input logic stop_b);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stop_b);
  endtask

  task automatic send_data(input logic [63:0] ops, input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(1'b0, ops[63-8*k -: 8], 1'b1);
  endtask

  task automatic send_frame(input logic [63:0] ops, input logic [7:0] ctl);
    send_data(ops, 8);
    send_byte(1'b1, ctl, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_operands", operands_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_op", 64'(op_out), 64'h7);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_err_valid", 64'(err_valid), 64'd0);
    check("reset_err_flags", 64'(err_flags), 64'd0);
    rst = 1'b0;
    idle(3);

    // Zero operands, AND: CRC over 64 zeros,1,000 = 1011
    push_good(64'd0, OP_AND);
    send_frame(64'd0, 8'h0B);
    idle(2);

    // ADD (CRC 0111) then back-to-back frame with a bad CRC
    push_good(64'd0, OP_ADD);
    send_frame(64'd0, 8'h47);
    push_err(ERR_CRC);
    send_frame(64'd0, 8'h46);
    idle(2);

    // Non-trivial operand patterns, back-to-back
    push_good(A, OP_SUB);
    send_frame(A, ctl_of(A, OP_SUB));
    push_good(B, OP_OR);
    send_frame(B, ctl_of(B, OP_OR));
    idle(2);

    // Ctl byte arrives after only 7 data bytes, then resync and a good frame
    push_err(ERR_DATA);
    send_data(64'd0, 7);
    send_byte(1'b1, 8'h0B, 1'b1);
    idle(11);
    push_good(A, OP_ADD);
    send_frame(A, ctl_of(A, OP_ADD));
    idle(2);

    // Stop bit 0 in data byte 3; 10 ones then a 0 keeps the receiver in ERROR,
    // so the following frame is swallowed; 11 ones then recover
    push_err(ERR_DATA);
    send_data(A, 3);
    send_byte(1'b0, A[39:32], 1'b0);
    idle(10);
    send_bit(1'b0);
    send_frame(64'd0, 8'h0B);
    idle(11);
    push_good(B, OP_ADD);
    send_frame(B, ctl_of(B, OP_ADD));
    idle(2);

    // Correct CRC with an illegal opcode (010): CRC = 1101
    push_err(ERR_OP);
    send_frame(64'd0, 8'h2D);
    idle(2);

    // Reset during the payload of byte 5
    send_data(A, 5);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sin = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_operands", operands_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("midrst_op", 64'(op_out), 64'h7);
    check("midrst_err_flags", 64'(err_flags), 64'd0);
    check("midrst_strobes", 64'({out_valid, err_valid}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_ops = '1;
    last_op  = 3'b111;
    idle(2);

    // A CRC error straight after reset must leave the reset values in place
    push_err(ERR_CRC);
    send_frame(64'd0, 8'h0A);
    push_good(B, OP_SUB);
    send_frame(B, ctl_of(B, OP_SUB));
    idle(4);

    check("pending_expectations", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
